uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Receive front end of the UART: oversamples the serial Rx line on SysClk, detects the start bit, and samples data, parity and stop bits at bit centres.
- Presents each received word to the receive FIFO as a one-cycle write strobe with error flags.
- Drives RTS from FIFO back-pressure.
- Sits between the Rx pin and the receive FIFO; its Data_Rdy feeds the FIFO write port.

Parameters:
- SYSCLK_RATE, 100000000, SysClk frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- DATA_BITS, 8, data bits per frame.
- PARITY_BIT, 1, 1 = one even-parity bit follows the data; 0 = no parity bit.
- STOP_BITS, 2, stop bits per frame (1 or 2).
- CLKS_PER_BIT, SYSCLK_RATE/BAUD_RATE (integer division), SysClk cycles per bit. Overridable for simulation; minimum 4.

Ports:
- SysClk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Rx  in  1  serial line, asynchronous to SysClk; idle high.
- FIFO_Full  in  1  receive FIFO cannot accept a write.
- RTS  out  1  ready-to-send to the remote transmitter.
- Data_Out  out  DATA_BITS  last received data word.
- Data_Rdy  out  1  one-cycle FIFO write strobe.
- Rx_Error  out  3  [0] break, [1] parity, [2] frame; valid with Data_Rdy.
- Rx_Overrun  out  1  one-cycle pulse: frame dropped because the FIFO was full.
- Rx_Busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- **Reset (Rst low, async)**
  - Data_Out=0, Data_Rdy=0, Rx_Error=0, Rx_Overrun=0, Rx_Busy=0, RTS=0.
  - State=IDLE, counters cleared, synchroniser flops set to 1.
  - Reset mid-frame aborts the frame with no strobe.
- **Synchroniser:** Rx passes through two flops. "rxs" below is the synchronised value, which lags Rx by 2 cycles.
- **RTS:** registered NOT FIFO_Full, so it updates 1 cycle after FIFO_Full changes. Low during reset.
- **Frame order:** start(0), data MSB first (bit DATA_BITS-1 first), parity if PARITY_BIT, then STOP_BITS stop bits of 1.
- **Parity:** even; expected parity = XOR of all data bits.
- **Bit counter:** bit-period counter counts 0..CLKS_PER_BIT-1. The sample point is count == CLKS_PER_BIT/2 - 1 in START; subsequent samples occur every CLKS_PER_BIT cycles.
- **States and transitions:**
  - IDLE: rxs falls to 0 → START, counter cleared, Rx_Busy=1.
  - START: at the mid sample, if rxs=1 (glitch) → IDLE with no outputs; otherwise → DATA.
  - DATA: one sample per bit into a shift register (shift left, LSB in), DATA_BITS samples → PARITY (or STOP if PARITY_BIT=0).
  - PARITY: one sample, compared with the expected parity → STOP.
  - STOP: STOP_BITS samples; after the last sample → DELIVER.
  - DELIVER: one cycle that issues the strobe (see below).
    - Returns to IDLE if the last stop sample was 1.
    - Otherwise → LINE_WAIT.
  - LINE_WAIT: remains until rxs=1 for one full bit period → IDLE. This prevents a held-low line from re-triggering.
- **Error flags:**
  - Break: start, all data, parity and all stop samples are 0. Only Rx_Error[0] is set; [1] and [2] are forced to 0.
  - Otherwise, Rx_Error[1] = parity mismatch and Rx_Error[2] = any stop sample is 0. Both may be set together.
- **Strobe:**
  - Delivery happens in the DELIVER cycle, which is the cycle after the last stop-bit sample.
  - If FIFO_Full=0: Data_Rdy=1 for exactly one cycle, with Data_Out and Rx_Error updated in the same cycle.
  - If FIFO_Full=1: Data_Rdy stays 0, Rx_Overrun=1 for one cycle, and Data_Out and Rx_Error are unchanged.
  - Data is delivered even when error flags are set.
- **Holding:** Data_Out and Rx_Error hold until the next delivery. Rx_Error is not cleared by a new start bit.
- **Rx_Busy:** falls on entry to IDLE.
- **Back-to-back frames:** a start edge seen in the cycle immediately after the return to IDLE must be accepted. No dead time beyond DELIVER.

Test Plan:
- **Valid frame:** CLKS_PER_BIT=16, defaults otherwise, send 0xA5 (parity 0, stops 11) → one Data_Rdy pulse, Data_Out=0xA5, Rx_Error=3'b000, RTS stays 1.
- **Parity error:** send 0xAA with parity bit 1 → Data_Out=0xAA, Rx_Error=3'b010.
- **Frame error:** send 0xAA with stops 00, then idle high → Rx_Error=3'b100.
  - Passes through LINE_WAIT.
  - No second strobe until the next start bit.
- **Break:** hold Rx low for 12 bit periods, then high → Rx_Error=3'b001, Data_Out=0x00, exactly one strobe.
  - Next frame 0x3C received cleanly with Rx_Error=3'b000.
- **Glitch and back-to-back:** a 3-cycle low pulse on Rx produces no strobe and Rx_Busy returns to 0.
  - Then frames 0x00, 0xFF, 0x81 sent with no idle gap → three strobes with the correct data, all errors 0.
- **Full FIFO and mid-frame reset:**
  - FIFO_Full=1, send 0x55 → Rx_Overrun pulse, no Data_Rdy, Data_Out unchanged, RTS=0.
  - Assert Rst mid-data-bit → all outputs 0 immediately; the following frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_deframer_if.sv
// Receive-side bus of the UART deframer: serial line in, FIFO write port and
// flow-control out. The deframer uses the master view, the FIFO side uses slave.
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic                 Rx;
    logic                 FIFO_Full;
    logic                 RTS;
    logic [DATA_BITS-1:0] Data_Out;
    logic                 Data_Rdy;
    logic [2:0]           Rx_Error;
    logic                 Rx_Overrun;
    logic                 Rx_Busy;

    modport master (
        input  Rx, FIFO_Full,
        output RTS, Data_Out, Data_Rdy, Rx_Error, Rx_Overrun, Rx_Busy
    );

    modport slave (
        output Rx, FIFO_Full,
        input  RTS, Data_Out, Data_Rdy, Rx_Error, Rx_Overrun, Rx_Busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises Rx, finds the start bit, samples each
// bit at its centre, then hands the word to the receive FIFO as a one-cycle
// strobe with break/parity/frame flags. RTS follows FIFO back-pressure.
module uart_rx_deframer #(
    parameter int SYSCLK_RATE  = 100000000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_BIT   = 1,
    parameter int STOP_BITS    = 2,
    parameter int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE
) (
    input  logic                  SysClk,
    input  logic                  Rst,
    uart_rx_deframer_if.master    bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DELIVER, LINE_WAIT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           sync;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;
    logic                 stop_err;
    logic                 any_one;
    logic                 last_stop;
    logic                 sample_en;
    logic                 mid_hit;
    logic                 end_hit;
    logic                 brk;
    logic                 stop_bad;
    logic                 rts;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_rdy;
    logic [2:0]           rx_error;
    logic                 overrun;

    assign rxs      = sync[1];
    assign mid_hit  = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign end_hit  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign brk      = !any_one && !rxs;
    assign stop_bad = stop_err || !rxs;

    // Two-flop synchroniser for the asynchronous Rx line, idling high
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) sync <= 2'b11;
        else      sync <= {sync[0], bus.Rx};
    end

    // State register
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and bit-centre sample enables
    always_comb begin
        state_nxt = state;
        sample_en = 1'b0;
        case (state)
            IDLE:      if (!rxs) state_nxt = START;
            START:     if (mid_hit) state_nxt = rxs ? IDLE : DATA;
            DATA: begin
                if (end_hit) begin
                    sample_en = 1'b1;
                    if (idx == IDX_W'(DATA_BITS - 1))
                        state_nxt = (PARITY_BIT != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (end_hit) begin
                    sample_en = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (end_hit) begin
                    sample_en = 1'b1;
                    if (idx == IDX_W'(STOP_BITS - 1)) state_nxt = DELIVER;
                end
            end
            DELIVER:   state_nxt = last_stop ? IDLE : LINE_WAIT;
            LINE_WAIT: if (rxs && end_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bit-period counter and per-state bit index; both restart on every state change
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state == IDLE || state == DELIVER || end_hit ||
                     (state == LINE_WAIT && !rxs))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state_nxt != state)
                idx <= '0;
            else if (sample_en)
                idx <= idx + 1'b1;
        end
    end

    // Frame capture: shift in data, track parity, stop and break evidence
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            shift     <= '0;
            par_err   <= 1'b0;
            stop_err  <= 1'b0;
            any_one   <= 1'b0;
            last_stop <= 1'b1;
        end else if (state == IDLE && state_nxt == START) begin
            par_err  <= 1'b0;
            stop_err <= 1'b0;
            any_one  <= 1'b0;
        end else if (sample_en) begin
            any_one <= any_one | rxs;
            case (state)
                DATA:    shift <= DATA_BITS'({shift, rxs});
                PARITY:  par_err <= rxs ^ (^shift);
                STOP: begin
                    stop_err  <= stop_err | ~rxs;
                    last_stop <= rxs;
                end
                default: ;
            endcase
        end
    end

    // Delivery: loaded on the last stop sample so the strobe occupies the DELIVER cycle
    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            data_out <= '0;
            data_rdy <= 1'b0;
            rx_error <= 3'b000;
            overrun  <= 1'b0;
            rts      <= 1'b0;
        end else begin
            rts      <= ~bus.FIFO_Full;
            data_rdy <= 1'b0;
            overrun  <= 1'b0;
            if (state == STOP && state_nxt == DELIVER) begin
                if (!bus.FIFO_Full) begin
                    data_rdy <= 1'b1;
                    data_out <= shift;
                    rx_error <= brk ? 3'b001 : {stop_bad, par_err, 1'b0};
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.RTS        = rts;
    assign bus.Data_Out   = data_out;
    assign bus.Data_Rdy   = data_rdy;
    assign bus.Rx_Error   = rx_error;
    assign bus.Rx_Overrun = overrun;
    assign bus.Rx_Busy    = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 16 clocks per bit, 8E2 framing.
module tb_uart_rx_deframer;
    localparam int CPB = 16;

    logic SysClk = 1'b0;
    logic Rst    = 1'b0;

    int checkCount    = 0;
    int passCount     = 0;
    int overrunCount  = 0;
    logic [7:0] dataQ[$];
    logic [2:0] errQ[$];

    uart_rx_deframer_if #(.DATA_BITS(8)) bus ();

    uart_rx_deframer #(
        .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2), .CLKS_PER_BIT(CPB)
    ) dut (
        .SysClk(SysClk),
        .Rst(Rst),
        .bus(bus)
    );

    // Free-running 100 MHz clock
    always #5 SysClk = ~SysClk;

    // Record every FIFO write and overrun pulse, sampled away from the active edge
    always @(negedge SysClk) begin
        if (bus.Data_Rdy) begin
            dataQ.push_back(bus.Data_Out);
            errQ.push_back(bus.Rx_Error);
        end
        if (bus.Rx_Overrun) overrunCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Hold the line at one level for a number of cycles, staying 1 ns past the edge
    task automatic holdLine(input logic level, input int cycles);
        bus.Rx = level;
        repeat (cycles) @(posedge SysClk);
        #1;
    endtask

    // Send one frame: start, data MSB first, parity bit, then two stop bits
    task automatic applyStimulus(input logic [7:0] data, input logic par,
                                 input logic [1:0] stops);
        holdLine(1'b0, CPB);
        for (int i = 7; i >= 0; i--) holdLine(data[i], CPB);
        holdLine(par, CPB);
        holdLine(stops[1], CPB);
        holdLine(stops[0], CPB);
    endtask

    task automatic clearLog();
        dataQ.delete();
        errQ.delete();
    endtask

    initial begin
        bus.Rx        = 1'b1;
        bus.FIFO_Full = 1'b0;
        repeat (4) @(posedge SysClk);
        #1;

        // Reset state
        checkOutput("reset Data_Out", 32'(bus.Data_Out), 32'h00);
        checkOutput("reset Data_Rdy", 32'(bus.Data_Rdy), 32'h0);
        checkOutput("reset Rx_Error", 32'(bus.Rx_Error), 32'h0);
        checkOutput("reset Rx_Busy", 32'(bus.Rx_Busy), 32'h0);
        checkOutput("reset RTS", 32'(bus.RTS), 32'h0);
        Rst = 1'b1;
        holdLine(1'b1, 20);
        checkOutput("RTS after reset", 32'(bus.RTS), 32'h1);

        // Valid frame
        clearLog();
        applyStimulus(8'hA5, 1'b0, 2'b11);
        holdLine(1'b1, 40);
        checkOutput("valid strobes", 32'(dataQ.size()), 32'd1);
        if (dataQ.size() == 1) begin
            checkOutput("valid data", 32'(dataQ[0]), 32'hA5);
            checkOutput("valid err", 32'(errQ[0]), 32'h0);
        end
        checkOutput("valid RTS", 32'(bus.RTS), 32'h1);
        checkOutput("valid busy", 32'(bus.Rx_Busy), 32'h0);

        // Parity error
        clearLog();
        applyStimulus(8'hAA, 1'b1, 2'b11);
        holdLine(1'b1, 40);
        checkOutput("parity strobes", 32'(dataQ.size()), 32'd1);
        checkOutput("parity data", 32'(bus.Data_Out), 32'hAA);
        checkOutput("parity err", 32'(bus.Rx_Error), 32'h2);

        // Frame error, passes through LINE_WAIT
        clearLog();
        applyStimulus(8'hAA, 1'b0, 2'b00);
        holdLine(1'b1, 60);
        checkOutput("frame strobes", 32'(dataQ.size()), 32'd1);
        checkOutput("frame data", 32'(bus.Data_Out), 32'hAA);
        checkOutput("frame err", 32'(bus.Rx_Error), 32'h4);
        checkOutput("frame busy", 32'(bus.Rx_Busy), 32'h0);

        // Break: line low for 12 bit periods
        clearLog();
        holdLine(1'b0, 12 * CPB);
        checkOutput("break busy in wait", 32'(bus.Rx_Busy), 32'h1);
        holdLine(1'b1, 60);
        checkOutput("break strobes", 32'(dataQ.size()), 32'd1);
        checkOutput("break data", 32'(bus.Data_Out), 32'h00);
        checkOutput("break err", 32'(bus.Rx_Error), 32'h1);
        checkOutput("break busy", 32'(bus.Rx_Busy), 32'h0);

        // Clean frame after break
        clearLog();
        applyStimulus(8'h3C, 1'b0, 2'b11);
        holdLine(1'b1, 40);
        checkOutput("after break strobes", 32'(dataQ.size()), 32'd1);
        checkOutput("after break data", 32'(bus.Data_Out), 32'h3C);
        checkOutput("after break err", 32'(bus.Rx_Error), 32'h0);

        // Glitch rejection
        clearLog();
        holdLine(1'b0, 3);
        holdLine(1'b1, 4);
        checkOutput("glitch busy rise", 32'(bus.Rx_Busy), 32'h1);
        holdLine(1'b1, 30);
        checkOutput("glitch strobes", 32'(dataQ.size()), 32'd0);
        checkOutput("glitch busy", 32'(bus.Rx_Busy), 32'h0);

        // Back-to-back frames with no idle gap
        clearLog();
        applyStimulus(8'h00, 1'b0, 2'b11);
        applyStimulus(8'hFF, 1'b0, 2'b11);
        applyStimulus(8'h81, 1'b0, 2'b11);
        holdLine(1'b1, 40);
        checkOutput("b2b strobes", 32'(dataQ.size()), 32'd3);
        if (dataQ.size() == 3) begin
            checkOutput("b2b data0", 32'(dataQ[0]), 32'h00);
            checkOutput("b2b data1", 32'(dataQ[1]), 32'hFF);
            checkOutput("b2b data2", 32'(dataQ[2]), 32'h81);
            checkOutput("b2b errs", 32'({errQ[0], errQ[1], errQ[2]}), 32'h0);
        end

        // Full FIFO: overrun, no strobe, RTS low
        clearLog();
        overrunCount = 0;
        bus.FIFO_Full = 1'b1;
        holdLine(1'b1, 3);
        checkOutput("full RTS", 32'(bus.RTS), 32'h0);
        applyStimulus(8'h55, 1'b0, 2'b11);
        holdLine(1'b1, 40);
        checkOutput("full overruns", 32'(overrunCount), 32'd1);
        checkOutput("full strobes", 32'(dataQ.size()), 32'd0);
        checkOutput("full data held", 32'(bus.Data_Out), 32'h81);
        bus.FIFO_Full = 1'b0;
        holdLine(1'b1, 3);
        checkOutput("unfull RTS", 32'(bus.RTS), 32'h1);

        // Reset in the middle of a data bit
        clearLog();
        holdLine(1'b0, CPB);
        holdLine(1'b0, CPB);
        holdLine(1'b1, CPB / 2);
        Rst = 1'b0;
        #1;
        checkOutput("midreset Data_Out", 32'(bus.Data_Out), 32'h00);
        checkOutput("midreset Rx_Busy", 32'(bus.Rx_Busy), 32'h0);
        checkOutput("midreset RTS", 32'(bus.RTS), 32'h0);
        checkOutput("midreset Rx_Error", 32'(bus.Rx_Error), 32'h0);
        holdLine(1'b1, 5);
        Rst = 1'b1;
        holdLine(1'b1, 40);
        checkOutput("midreset no strobe", 32'(dataQ.size()), 32'd0);
        applyStimulus(8'h12, 1'b0, 2'b11);
        holdLine(1'b1, 40);
        checkOutput("post reset strobes", 32'(dataQ.size()), 32'd1);
        checkOutput("post reset data", 32'(bus.Data_Out), 32'h12);
        checkOutput("post reset err", 32'(bus.Rx_Error), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
